// File: rtl/zap_pkg.sv
// Shared types and helpers for the Zapper hit sequencer.
// Holds the state enum, target limit and one-hot helper.
package zap_pkg;

  localparam int MAX_TARGETS = 16;
  localparam int MAX_IDX_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLANK,
    SCAN,
    DONE,
    REARM
  } zap_state_e;

  function automatic logic [MAX_TARGETS-1:0] onehot(
    input logic [MAX_IDX_W-1:0] idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/zap_hit_sequencer_if.sv
// Handshake bundle between game/video side and the hit sequencer.
// Optional cheat pulse exists only with ZAP_CHEAT_DETECT_EN.
interface zap_hit_sequencer_if #(
  parameter int NUM_TARGETS = 4,
  parameter int IDX_W       = 2
) ();

  logic                   frame_start;
  logic                   shot;
  logic                   hit;
  logic [NUM_TARGETS-1:0] target_mask;
  logic                   busy;
  logic                   blank_screen;
  logic [NUM_TARGETS-1:0] highlight;
  logic                   result_valid;
  logic                   result_hit;
  logic [IDX_W-1:0]       result_idx;
`ifdef ZAP_CHEAT_DETECT_EN
  logic                   cheat;
`endif

  modport master (
    output frame_start,
    output shot,
    output hit,
    output target_mask,
    input  busy,
    input  blank_screen,
    input  highlight,
    input  result_valid,
    input  result_hit,
`ifdef ZAP_CHEAT_DETECT_EN
    input  cheat,
`endif
    input  result_idx
  );

  modport slave (
    input  frame_start,
    input  shot,
    input  hit,
    input  target_mask,
    output busy,
    output blank_screen,
    output highlight,
    output result_valid,
    output result_hit,
`ifdef ZAP_CHEAT_DETECT_EN
    output cheat,
`endif
    output result_idx
  );

endinterface

// File: rtl/zap_next_target.sv
// Priority finder: lowest set mask bit at or above i_from.
// Used both for the first-target search and for advancing.
module zap_next_target
  import zap_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_TARGETS-1:0] i_mask,
  input  logic [IDX_W-1:0]       i_from,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_found
);

  // scan from the top so the lowest eligible bit wins
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (i_mask[i] && (i >= int'(i_from))) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zap_hit_sequencer.sv
// Frame-level Zapper hit sequencer: blank frame(s), then one lit target per frame.
// Build option ZAP_CHEAT_DETECT_EN flags light seen during blanking.
module zap_hit_sequencer
  import zap_pkg::*;
#(
  parameter int NUM_TARGETS  = 4,
  parameter int IDX_W        = 2,
  parameter int BLANK_FRAMES = 1
) (
  input  logic               clk,
  input  logic               reset,
  zap_hit_sequencer_if.slave io_bus
);

  zap_state_e             r_state, w_state_nxt;
  logic [NUM_TARGETS-1:0] r_mask, w_mask_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [1:0]             r_frame_cnt, w_cnt_nxt;
  logic                   r_hit_flag, w_hflag_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_blank, w_blank_nxt;
  logic [NUM_TARGETS-1:0] r_hl, w_hl_nxt;
  logic                   r_rv, w_rv_nxt;
  logic                   r_rh, w_rh_nxt;
  logic [IDX_W-1:0]       r_ri, w_ri_nxt;
`ifdef ZAP_CHEAT_DETECT_EN
  logic                   r_cheat_flag, w_cflag_nxt;
  logic                   r_cheat, w_cheat_nxt;
`endif

  logic                   w_go_done;
  logic                   w_cnt_last;
  logic [NUM_TARGETS-1:0] w_oh_cur;
  logic [NUM_TARGETS-1:0] w_oh_next;
  logic [NUM_TARGETS-1:0] w_srch_mask;
  logic [IDX_W-1:0]       w_srch_from;
  logic [IDX_W-1:0]       w_next_idx;
  logic                   w_found;

  assign w_oh_cur   = NUM_TARGETS'(onehot(MAX_IDX_W'(r_idx)));
  assign w_oh_next  = NUM_TARGETS'(onehot(MAX_IDX_W'(w_next_idx)));
  assign w_cnt_last = (r_frame_cnt == 2'(BLANK_FRAMES - 1));

  // in SCAN drop the current target, elsewhere search from bit 0
  assign w_srch_mask = (r_state == SCAN) ? (r_mask & ~w_oh_cur) : r_mask;
  assign w_srch_from = (r_state == SCAN) ? r_idx : '0;

  zap_next_target #(
    .NUM_TARGETS (NUM_TARGETS),
    .IDX_W       (IDX_W)
  ) u_next (
    .i_mask  (w_srch_mask),
    .i_from  (w_srch_from),
    .o_idx   (w_next_idx),
    .o_found (w_found)
  );

  // next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_frame_cnt;
    w_hflag_nxt = r_hit_flag;
    w_busy_nxt  = r_busy;
    w_blank_nxt = r_blank;
    w_hl_nxt    = r_hl;
    w_rv_nxt    = 1'b0;
    w_rh_nxt    = 1'b0;
    w_ri_nxt    = '0;
    w_go_done   = 1'b0;
`ifdef ZAP_CHEAT_DETECT_EN
    w_cflag_nxt = r_cheat_flag;
    w_cheat_nxt = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (io_bus.shot) begin
          w_mask_nxt  = io_bus.target_mask;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        if (io_bus.frame_start) begin
          w_blank_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_hflag_nxt = 1'b0;
`ifdef ZAP_CHEAT_DETECT_EN
          w_cflag_nxt = 1'b0;
`endif
          w_state_nxt = BLANK;
        end
      end
      BLANK: begin
`ifdef ZAP_CHEAT_DETECT_EN
        if (io_bus.hit) w_cflag_nxt = 1'b1;
`endif
        if (io_bus.frame_start) begin
          w_cnt_nxt = r_frame_cnt + 2'd1;
          if (w_cnt_last) begin
`ifdef ZAP_CHEAT_DETECT_EN
            if (r_cheat_flag || io_bus.hit) begin
              w_go_done   = 1'b1;
              w_cheat_nxt = 1'b1;
            end else
`endif
            if (w_found) begin
              w_idx_nxt   = w_next_idx;
              w_hl_nxt    = w_oh_next;
              w_hflag_nxt = 1'b0;
              w_state_nxt = SCAN;
            end else begin
              w_go_done = 1'b1;
            end
          end
        end
      end
      SCAN: begin
        if (io_bus.hit) w_hflag_nxt = 1'b1;
        if (io_bus.frame_start) begin
          if (r_hit_flag || io_bus.hit) begin
            w_go_done = 1'b1;
            w_rh_nxt  = 1'b1;
            w_ri_nxt  = r_idx;
          end else begin
            w_mask_nxt  = r_mask & ~w_oh_cur;
            w_hflag_nxt = 1'b0;
            if (w_found) begin
              w_idx_nxt = w_next_idx;
              w_hl_nxt  = w_oh_next;
            end else begin
              w_go_done = 1'b1;
            end
          end
        end
      end
      DONE: begin
        w_state_nxt = REARM;
      end
      REARM: begin
        if (!io_bus.shot) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_go_done) begin
      w_state_nxt = DONE;
      w_busy_nxt  = 1'b0;
      w_blank_nxt = 1'b0;
      w_hl_nxt    = '0;
      w_rv_nxt    = 1'b1;
    end
  end

  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_mask       <= '0;
      r_idx        <= '0;
      r_frame_cnt  <= '0;
      r_hit_flag   <= 1'b0;
      r_busy       <= 1'b0;
      r_blank      <= 1'b0;
      r_hl         <= '0;
      r_rv         <= 1'b0;
      r_rh         <= 1'b0;
      r_ri         <= '0;
`ifdef ZAP_CHEAT_DETECT_EN
      r_cheat_flag <= 1'b0;
      r_cheat      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_mask       <= w_mask_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_cnt  <= w_cnt_nxt;
      r_hit_flag   <= w_hflag_nxt;
      r_busy       <= w_busy_nxt;
      r_blank      <= w_blank_nxt;
      r_hl         <= w_hl_nxt;
      r_rv         <= w_rv_nxt;
      r_rh         <= w_rh_nxt;
      r_ri         <= w_ri_nxt;
`ifdef ZAP_CHEAT_DETECT_EN
      r_cheat_flag <= w_cflag_nxt;
      r_cheat      <= w_cheat_nxt;
`endif
    end
  end

  assign io_bus.busy         = r_busy;
  assign io_bus.blank_screen = r_blank;
  assign io_bus.highlight    = r_hl;
  assign io_bus.result_valid = r_rv;
  assign io_bus.result_hit   = r_rh;
  assign io_bus.result_idx   = r_ri;
`ifdef ZAP_CHEAT_DETECT_EN
  assign io_bus.cheat        = r_cheat;
`endif

endmodule

// File: tb/tb_zap_hit_sequencer.sv
// Bench for zap_hit_sequencer: vector table plus hand sequences.
// Results are matched against a queue of expectations.
module tb_zap_hit_sequencer;

  logic clk;
  logic reset;

  zap_hit_sequencer_if #(.NUM_TARGETS(4), .IDX_W(2)) bus ();

  zap_hit_sequencer #(
    .NUM_TARGETS  (4),
    .IDX_W        (2),
    .BLANK_FRAMES (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    int          hit_f;
    int          exp_hit;
    int          exp_idx;
    int          exp_lit;
    logic [15:0] exp_hl;
    int          exp_fs;
    int          exp_cheat;
  } vec_t;

  typedef struct {
    int hit;
    int idx;
    int cheat;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] hl_log[$];
  logic [3:0] prev_hl;
  vec_t       vecs[9];
  int         n_vec;
  int         n_err;
  int         n_res;
  int         cur_fs;
  int         res_fs;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.highlight != prev_hl) begin
      if (bus.highlight != 4'd0) hl_log.push_back(bus.highlight);
      prev_hl = bus.highlight;
    end
    if (bus.result_valid) begin
      n_res++;
      res_fs = cur_fs;
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result_hit", int'(bus.result_hit), e.hit);
        chk("result_idx", int'(bus.result_idx), e.idx);
`ifdef ZAP_CHEAT_DETECT_EN
        chk("cheat", int'(bus.cheat), e.cheat);
`endif
      end
    end
  endtask

  task automatic frame(input int f, input bit h);
    cur_fs = f;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    cur_fs = -1;
    bus.hit = h;
    repeat (3) tick();
    bus.hit = 1'b0;
    repeat (2) tick();
  endtask

  task automatic push_exp(input int h, input int idx, input int c);
    exp_t e;
    e.hit   = h;
    e.idx   = idx;
    e.cheat = c;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int   r0;
    logic [15:0] hl;
    bus.target_mask = v.mask;
    bus.shot = 1'b1;
    tick();
    chk("busy_on_accept", int'(bus.busy), 1);
    push_exp(v.exp_hit, v.exp_idx, v.exp_cheat);
    bus.target_mask = ~v.mask;
    bus.shot = 1'b0;
    hl_log.delete();
    r0 = n_res;
    res_fs = -1;
    for (int f = 0; f < 8 && sb.size() > 0; f++)
      frame(f, (v.hit_f == f));
    if (sb.size() > 0) begin
      chk("result_timeout", sb.size(), 0);
      sb.delete();
    end
    chk("result_fs", res_fs, v.exp_fs);
    chk("result_count", n_res - r0, 1);
    chk("lit_frames", hl_log.size(), v.exp_lit);
    hl = v.exp_hl;
    for (int k = 0; k < v.exp_lit && k < hl_log.size(); k++)
      chk("highlight", int'(hl_log[k]), int'(hl[4*k +: 4]));
    chk("busy_end", int'(bus.busy), 0);
    chk("blank_end", int'(bus.blank_screen), 0);
    tick();
  endtask

  initial begin
    int r0;
    n_vec = 0;
    n_err = 0;
    n_res = 0;
    cur_fs = -1;
    res_fs = -1;
    prev_hl = 4'd0;
    vecs[0] = '{4'b1111,  2, 1, 1, 2, 16'h0021, 3, 0};
    vecs[1] = '{4'b1010, -1, 0, 0, 2, 16'h0082, 3, 0};
    vecs[2] = '{4'b0000, -1, 0, 0, 0, 16'h0000, 1, 0};
    vecs[3] = '{4'b0100,  1, 1, 2, 1, 16'h0004, 2, 0};
    vecs[4] = '{4'b1001,  2, 1, 3, 2, 16'h0081, 3, 0};
    vecs[5] = '{4'b1111, -1, 0, 0, 4, 16'h8421, 5, 0};
    vecs[6] = '{4'b0110,  1, 1, 1, 1, 16'h0002, 2, 0};
    vecs[7] = '{4'b1111,  1, 1, 0, 1, 16'h0001, 2, 0};
`ifdef ZAP_CHEAT_DETECT_EN
    vecs[8] = '{4'b0001,  0, 0, 0, 0, 16'h0000, 1, 1};
`else
    vecs[8] = '{4'b0001,  0, 0, 0, 1, 16'h0001, 2, 0};
`endif

    reset = 1'b0;
    bus.frame_start = 1'b0;
    bus.shot = 1'b0;
    bus.hit = 1'b0;
    bus.target_mask = 4'd0;
    repeat (3) tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_blank", int'(bus.blank_screen), 0);
    chk("rst_hl", int'(bus.highlight), 0);
    chk("rst_rv", int'(bus.result_valid), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // shot held long after the result must not retrigger
    r0 = n_res;
    bus.target_mask = 4'b0001;
    bus.shot = 1'b1;
    tick();
    push_exp(0, 0, 0);
    for (int f = 0; f < 3; f++) frame(f, 1'b0);
    for (int f = 10; f < 20; f++) frame(f, 1'b0);
    chk("held_count", n_res - r0, 1);
    chk("held_busy", int'(bus.busy), 0);
    bus.shot = 1'b0;
    tick();
    bus.shot = 1'b1;
    tick();
    chk("rearm_busy", int'(bus.busy), 1);
    push_exp(1, 0, 0);
    bus.shot = 1'b0;
    frame(0, 1'b0);
    frame(1, 1'b1);
    frame(2, 1'b0);
    chk("rearm_count", n_res - r0, 2);
    if (sb.size() > 0) begin
      chk("rearm_timeout", sb.size(), 0);
      sb.delete();
    end

    // reset while a target is lit aborts without a result
    r0 = n_res;
    bus.target_mask = 4'b1111;
    bus.shot = 1'b1;
    tick();
    bus.shot = 1'b0;
    frame(0, 1'b0);
    frame(1, 1'b0);
    chk("pre_rst_hl", int'(bus.highlight), 1);
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_blank", int'(bus.blank_screen), 0);
    chk("mid_rst_hl", int'(bus.highlight), 0);
    chk("mid_rst_rv", int'(bus.result_valid), 0);
    reset = 1'b1;
    for (int f = 0; f < 3; f++) frame(f, 1'b1);
    chk("post_rst_count", n_res - r0, 0);
    chk("post_rst_busy", int'(bus.busy), 0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zap_hit_sequencer.md
Name: zap_hit_sequencer

Overview:
- Frame-level controller that sits between nes_zap and the video pipeline.
- On a new Zapper shot it forces a full black frame, then lights each active target white for one frame, one target at a time.
- It samples the Zapper hit line during each lit frame and reports which target, if any, was hit.
- The video renderer consumes blank_screen/highlight. Game logic consumes the one-cycle result pulse.

Parameters:
- NUM_TARGETS, 4, number of on-screen target slots (1..16).
- IDX_W, 2, width of target index; must equal clog2(NUM_TARGETS), minimum 1.
- BLANK_FRAMES, 1, black frames shown before the first target frame (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of each video frame (vsync edge).
- shot  in  1  level from nes_zap, high while a shot is in progress.
- hit  in  1  level from nes_zap, high when the photodiode sees light.
- target_mask  in  NUM_TARGETS  bit i = target i is alive and eligible.
- busy  out  1  high from shot acceptance until the result pulse.
- blank_screen  out  1  renderer draws the whole screen black.
- highlight  out  NUM_TARGETS  one-hot; renderer draws target i as a solid white box.
- result_valid  out  1  one-cycle pulse when the sequence completes.
- result_hit  out  1  qualified by result_valid; 1 = a target was hit.
- result_idx  out  IDX_W  qualified by result_valid and result_hit; index of the hit target.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; all outputs 0; mask register, index counter and frame counter cleared. Reset mid-sequence aborts with no result pulse.
- States: IDLE, ARM, BLANK, SCAN, DONE, REARM. Next-state logic is combinational; outputs are registered.
- IDLE: shot=1 → latch target_mask into mask_q, set busy=1, go to ARM. A frame_start in that same cycle does not count.
- ARM: wait for frame_start, then go to BLANK with blank_screen=1 and frame_cnt=0.
- BLANK: on each frame_start, increment frame_cnt. On the frame_start ending frame BLANK_FRAMES, search mask_q for the lowest set bit.
  - Bit found: go to SCAN, highlight=onehot(idx), blank_screen stays 1.
  - mask_q all zero: go to DONE with miss.
- SCAN, each lit frame:
  - Sticky hit_flag is set if hit=1 on any cycle of the frame.
  - At the next frame_start:
    - If hit_flag=1 (or hit=1 in that same cycle), go to DONE with hit, result_idx=idx.
    - Otherwise clear bit idx in mask_q and advance to the next higher set bit, one frame per target.
    - If no further set bit exists, go to DONE with miss.
  - Targets whose mask bit is 0 are skipped without spending a frame.
  - The lowest-index hit wins; remaining targets are not lit.
- DONE: exactly one cycle.
  - result_valid=1; result_hit/result_idx valid.
  - blank_screen=0, highlight=0, busy=0.
  - On a miss, result_idx=0.
- REARM: wait for shot=0, then return to IDLE. One shot produces exactly one result; a held shot does not retrigger.
- shot falling during ARM/BLANK/SCAN is ignored; the sequence completes.
- target_mask changes after acceptance are ignored.
- Latency for target k lit and hit, with all lower targets masked off: result_valid one cycle after the frame_start that ends the lit frame, which is (BLANK_FRAMES+1) frame_starts after ARM exits.

Optional Feature:
- Macro: ZAP_CHEAT_DETECT_EN.
- Defined: in BLANK, hit=1 on any cycle sets cheat_flag. At the end of the blanking period the block goes straight to DONE with result_hit=0, and a one-cycle output cheat pulses alongside result_valid. The cheat port exists only when the macro is defined.
- Undefined: hit is ignored in BLANK and the cheat port is absent.

Decomposition:
- Shared package zap_pkg holds:
  - the state enum (IDLE, ARM, BLANK, SCAN, DONE, REARM);
  - the MAX_TARGETS=16 constant;
  - an onehot-from-index helper function.
- One sub-module: zap_next_target. It is a combinational priority finder that takes mask_q and the current index and returns the next set index above it, plus a found flag. It is reused for the first-target search.

Test Plan:
- BLANK_FRAMES=1, mask=4'b1111, shot pulse, hit during frame 2 (target 1 lit) → highlight 0001 then 0010; result_valid with result_hit=1, result_idx=1 after 3 frame_starts.
- mask=4'b1010, no hit → highlight 0010, 1000, then result_hit=0, result_idx=0; exactly two lit frames.
- mask=4'b0000, shot → one black frame, then result_valid with result_hit=0; highlight never nonzero.
- shot held high for 10 frames after the result → exactly one result_valid; new sequence only after shot=0 then shot=1.
- reset=0 asserted during SCAN → next cycle all outputs 0, no result_valid, state IDLE; a subsequent shot runs normally.
- ZAP_CHEAT_DETECT_EN defined, hit=1 during BLANK, mask=4'b0001 → no SCAN frame; result_valid with result_hit=0 and cheat=1 at the end of the blank frame.
